branch_sequencer: RTL and testbench
===================================

// Module: branch_sequencer
// PURPOSE
//  Sequences the shared branch comparison unit for one branch/jump request at a time.
//  Accepts a request from decode over a valid/ready handshake and registers the operands.
//  Drives the comparator for one evaluation cycle, then resolves the branch.
//  On taken: issues a one-cycle PC redirect, then a programmable flush window; stalls upstream until done.
// PARAMETERS
//  XLEN          32  datapath/PC width
//  FLUSH_CYCLES  2   cycles flush held high after a redirect; legal 0..15
// PORTS
//  clk             in   1     single clock, all state on rising edge
//  rst             in   1     synchronous, active-high reset
//  req_valid       in   1     decode presents a branch/jump request
//  req_ready       out  1     sequencer can accept (IDLE only)
//  req_cntrl       in   3     000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 JAL, others none
//  req_d1/req_d2   in   XLEN  rs1/rs2 operand values
//  req_pc          in   XLEN  PC of the branch instruction
//  req_imm         in   XLEN  sign-extended offset
//  bu_d1/bu_d2     out  XLEN  operands to comparator
//  bu_cntrl        out  3     control to comparator; 000 whenever not in EVAL
//  bu_take         in   1     comparator result (combinational from bu_*)
//  stall           out  1     high in every state except IDLE
//  redirect_valid  out  1     one-cycle pulse: fetch loads redirect_pc
//  redirect_pc     out  XLEN  req_pc+req_imm, mod 2^XLEN; bits [1:0] unmodified
//  flush           out  1     squash younger instructions
//  resolved_valid  out  1     one-cycle pulse: branch outcome known
//  resolved_taken  out  1     outcome, qualified by resolved_valid
//  taken_count     out  32    count of taken resolutions, wraps at 2^32
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0 except req_ready=1. Captured regs and taken_count=0.
//  States:
//   IDLE  -> EVAL on req_valid && req_ready; capture cntrl/d1/d2/pc/imm.
//   EVAL  -> bu_* driven from captured regs; bu_take sampled at clock edge.
//            Taken -> REDIR; not taken -> IDLE.
//   REDIR -> one cycle; redirect_valid=1; next FLUSH, or IDLE if FLUSH_CYCLES==0.
//   FLUSH -> flush=1 for exactly FLUSH_CYCLES cycles; 4-bit down-counter; then IDLE.
//  Timing: accept edge T. EVAL during T+1.
//   Cycle T+2 (registered outputs): resolved_valid=1, resolved_taken=bu_take.
//   Cycle T+2, taken only: redirect_valid=1, with redirect_pc valid in the same cycle.
//   taken_count increments at the end of T+2 for taken branches.
//  Taken path: flush high T+3..T+2+FLUSH_CYCLES. req_ready=1 again at T+3+FLUSH_CYCLES.
//  Not-taken path: back in IDLE at T+2; req_ready=1 in T+2; no redirect, no flush.
//  cntrl 000 or 110/111: accepted, resolves not-taken (comparator returns 0).
//  cntrl 101 (JAL): always taken.
//  req_valid while busy: ignored (req_ready=0); decode holds request stable until accepted.
//  Back-to-back: a request presented in the IDLE cycle T+2 after a not-taken branch is accepted.
//  rst in any state, including mid-FLUSH: next cycle is IDLE with reset values.
//   The pending redirect is dropped; taken_count is cleared.
//  redirect_pc and the bu_* outputs hold their last captured values outside the pulse/EVAL;
//   consumers qualify them with redirect_valid / state.
//  taken_count: 0xFFFF_FFFF + 1 -> 0.
// TESTING
//  Reset: rst high for 2 cycles -> req_ready=1, stall=0, redirect_valid=0, flush=0, taken_count=0.
//  BEQ taken: cntrl=001, d1=d2=5, pc=0x100, imm=0x20.
//   -> T+2: resolved_valid=1, taken=1, redirect_valid=1, redirect_pc=0x120.
//   -> flush high exactly 2 cycles; req_ready returns at T+5.
//  BLT signed not taken: d1=0x0000_0001, d2=0xFFFF_FFFF.
//   -> T+2: resolved_valid=1, taken=0; no redirect/flush; a second request in T+2 is accepted.
//  Wrap: pc=0xFFFF_FFF0, imm=0x20, JAL (101) -> redirect_pc=0x0000_0010, taken_count += 1.
//  Reset mid-FLUSH: assert rst at T+3 of a taken BNE -> next cycle flush=0, stall=0, taken_count=0.
//  Busy: hold req_valid through a taken branch -> only one acceptance until req_ready rises;
//   with FLUSH_CYCLES=0 -> IDLE directly after REDIR, flush never asserted.

Source files
------------

// File: rtl/branch_sequencer.sv
// Branch sequencer: takes one branch/jump request, drives the shared comparator for a
// single evaluation cycle, then resolves, redirects and flushes as the outcome demands.
module branch_sequencer #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_cntrl,
    input  logic [XLEN-1:0] req_d1,
    input  logic [XLEN-1:0] req_d2,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_imm,
    output logic [XLEN-1:0] bu_d1,
    output logic [XLEN-1:0] bu_d2,
    output logic [2:0]      bu_cntrl,
    input  logic            bu_take,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            resolved_valid,
    output logic            resolved_taken,
    output logic [31:0]     taken_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        REDIR = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Counter is loaded with the last index so that it reaches zero in the final flush cycle.
    localparam logic [3:0] FLUSH_LAST = 4'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);

    state_t          state_q;
    logic [3:0]      flush_cnt_q;
    logic [XLEN-1:0] d1_q, d2_q, pc_q, imm_q;
    logic [2:0]      bu_cntrl_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            req_ready_q, stall_q, redirect_valid_q, flush_q;
    logic            resolved_valid_q, resolved_taken_q;
    logic [31:0]     taken_count_q;

    logic [XLEN-1:0] redirect_pc_d;
    logic [31:0]     taken_count_d;

    assign redirect_pc_d = pc_q + imm_q;
    assign taken_count_d = taken_count_q + 32'd1;

    // NOTE: every state register below uses non-blocking assignment so all flops update
    // together from the values present before the edge; blocking here would race.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            flush_cnt_q      <= '0;
            d1_q             <= '0;
            d2_q             <= '0;
            pc_q             <= '0;
            imm_q            <= '0;
            bu_cntrl_q       <= 3'b000;
            redirect_pc_q    <= '0;
            req_ready_q      <= 1'b1;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            resolved_valid_q <= 1'b0;
            resolved_taken_q <= 1'b0;
            taken_count_q    <= '0;
        end else begin
            resolved_valid_q <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        d1_q        <= req_d1;
                        d2_q        <= req_d2;
                        pc_q        <= req_pc;
                        imm_q       <= req_imm;
                        bu_cntrl_q  <= req_cntrl;
                        req_ready_q <= 1'b0;
                        stall_q     <= 1'b1;
                        state_q     <= EVAL;
                    end
                end
                EVAL: begin
                    bu_cntrl_q       <= 3'b000;
                    resolved_valid_q <= 1'b1;
                    resolved_taken_q <= bu_take;
                    if (bu_take) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= redirect_pc_d;
                        state_q          <= REDIR;
                    end else begin
                        req_ready_q <= 1'b1;
                        stall_q     <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                REDIR: begin
                    taken_count_q <= taken_count_d;
                    if (FLUSH_CYCLES == 0) begin
                        req_ready_q <= 1'b1;
                        stall_q     <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        flush_q     <= 1'b1;
                        flush_cnt_q <= FLUSH_LAST;
                        state_q     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == 4'd0) begin
                        flush_q     <= 1'b0;
                        req_ready_q <= 1'b1;
                        stall_q     <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand and redirect outputs hold their last captured values; consumers qualify them.
    assign bu_d1          = d1_q;
    assign bu_d2          = d2_q;
    assign bu_cntrl       = bu_cntrl_q;
    assign req_ready      = req_ready_q;
    assign stall          = stall_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign resolved_valid = resolved_valid_q;
    assign resolved_taken = resolved_taken_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios plus randomized requests against a
// behavioural model; a second instance runs with a zero-length flush window.
module tb_branch_sequencer;

    localparam int XLEN = 32;
    localparam int FLUSH_N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b0;
    logic            req_valid = 1'b0, req_ready;
    logic [2:0]      req_cntrl = '0;
    logic [XLEN-1:0] req_d1 = '0, req_d2 = '0, req_pc = '0, req_imm = '0;
    logic [XLEN-1:0] bu_d1, bu_d2, redirect_pc;
    logic [2:0]      bu_cntrl;
    logic            bu_take, stall, redirect_valid, flush, resolved_valid, resolved_taken;
    logic [31:0]     taken_count;

    logic            z_valid = 1'b0, z_ready;
    logic [2:0]      z_cntrl = '0;
    logic [XLEN-1:0] z_d1 = '0, z_d2 = '0, z_pc = '0, z_imm = '0;
    logic [XLEN-1:0] z_bu_d1, z_bu_d2, z_rpc;
    logic [2:0]      z_bu_cntrl;
    logic            z_bu_take, z_stall, z_rv, z_flush, z_resv, z_rest;
    logic [31:0]     z_count;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_count = '0;

    // Branch rule from the instruction set: signed compares for BLT/BGE, JAL always taken.
    function automatic logic exp_take(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b001:  return a == b;
            3'b010:  return a != b;
            3'b011:  return $signed(a) < $signed(b);
            3'b100:  return $signed(a) >= $signed(b);
            3'b101:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign bu_take   = exp_take(bu_cntrl, bu_d1, bu_d2);
    assign z_bu_take = exp_take(z_bu_cntrl, z_bu_d1, z_bu_d2);

    branch_sequencer #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_cntrl(req_cntrl), .req_d1(req_d1), .req_d2(req_d2), .req_pc(req_pc),
        .req_imm(req_imm), .bu_d1(bu_d1), .bu_d2(bu_d2), .bu_cntrl(bu_cntrl),
        .bu_take(bu_take), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .resolved_valid(resolved_valid),
        .resolved_taken(resolved_taken), .taken_count(taken_count)
    );

    branch_sequencer #(.XLEN(XLEN), .FLUSH_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
        .req_cntrl(z_cntrl), .req_d1(z_d1), .req_d2(z_d2), .req_pc(z_pc),
        .req_imm(z_imm), .bu_d1(z_bu_d1), .bu_d2(z_bu_d2), .bu_cntrl(z_bu_cntrl),
        .bu_take(z_bu_take), .stall(z_stall), .redirect_valid(z_rv),
        .redirect_pc(z_rpc), .flush(z_flush), .resolved_valid(z_resv),
        .resolved_taken(z_rest), .taken_count(z_count)
    );

    task automatic present(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] imm);
        req_valid = 1'b1;
        req_cntrl = c;
        req_d1    = a;
        req_d2    = b;
        req_pc    = pc;
        req_imm   = imm;
    endtask

    // Advances to the negedge where req_ready is high; returns cycles taken (-1 on timeout).
    task automatic wait_ready(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (req_ready) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_ready, stall, redirect_valid, flush, resolved_valid} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 10000", {req_ready, stall, redirect_valid, flush, resolved_valid});
        end
        n_checks++;
        if ({taken_count, bu_cntrl} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got count=%h cntrl=%b want 0", taken_count, bu_cntrl);
        end
        n_checks++;
        if ({z_ready, z_stall, z_flush, z_count} !== {3'b100, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_dut0: got ready=%b stall=%b flush=%b count=%h", z_ready, z_stall, z_flush, z_count);
        end
        rst = 1'b0;
        model_count = '0;
    endtask

    task automatic test_beq_taken;
        int nf = 0, first = -1, rdy = -1;
        present(3'b001, 32'd5, 32'd5, 32'h100, 32'h20);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({stall, req_ready, bu_cntrl} !== 5'b10001) begin
            n_fail++;
            $display("FAIL beq_eval: got stall=%b ready=%b cntrl=%b", stall, req_ready, bu_cntrl);
        end
        @(negedge clk);
        n_checks++;
        if ({resolved_valid, resolved_taken, redirect_valid, flush, bu_cntrl} !== 7'b1110000) begin
            n_fail++;
            $display("FAIL beq_resolve: got rv=%b rt=%b redir=%b flush=%b cntrl=%b",
                     resolved_valid, resolved_taken, redirect_valid, flush, bu_cntrl);
        end
        n_checks++;
        if (redirect_pc !== 32'h120) begin
            n_fail++;
            $display("FAIL beq_target: got %h want 00000120", redirect_pc);
        end
        model_count++;
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            if (flush) begin
                nf++;
                if (first < 0) first = k;
            end
            if (req_ready && rdy < 0) rdy = k;
        end
        n_checks++;
        if (nf !== 2 || first !== 3) begin
            n_fail++;
            $display("FAIL beq_flush: got %0d cycles from T+%0d want 2 from T+3", nf, first);
        end
        n_checks++;
        if (rdy !== 5) begin
            n_fail++;
            $display("FAIL beq_ready: got T+%0d want T+5", rdy);
        end
        n_checks++;
        if (taken_count !== model_count) begin
            n_fail++;
            $display("FAIL beq_count: got %0d want %0d", taken_count, model_count);
        end
    endtask

    task automatic test_blt_back_to_back;
        int cyc;
        present(3'b011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h200, 32'h40);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({resolved_valid, resolved_taken, redirect_valid, flush, req_ready, stall} !== 6'b100010) begin
            n_fail++;
            $display("FAIL blt_resolve: got rv=%b rt=%b redir=%b flush=%b ready=%b stall=%b",
                     resolved_valid, resolved_taken, redirect_valid, flush, req_ready, stall);
        end
        present(3'b100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h300, 32'h8);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({stall, bu_cntrl} !== 4'b1100) begin
            n_fail++;
            $display("FAIL b2b_accept: got stall=%b cntrl=%b want 1 100", stall, bu_cntrl);
        end
        @(negedge clk);
        n_checks++;
        if ({resolved_valid, resolved_taken, redirect_valid} !== 3'b111 || redirect_pc !== 32'h308) begin
            n_fail++;
            $display("FAIL b2b_resolve: got rv=%b rt=%b redir=%b pc=%h want 111 00000308",
                     resolved_valid, resolved_taken, redirect_valid, redirect_pc);
        end
        model_count++;
        wait_ready(cyc);
        n_checks++;
        if (cyc !== FLUSH_N + 1 || taken_count !== model_count) begin
            n_fail++;
            $display("FAIL b2b_done: got ready after %0d count=%0d want %0d count=%0d",
                     cyc, taken_count, FLUSH_N + 1, model_count);
        end
    endtask

    task automatic test_wrap;
        int cyc;
        present(3'b101, $urandom, $urandom, 32'hFFFF_FFF0, 32'h20);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL wrap_target: got redir=%b pc=%h want 1 00000010", redirect_valid, redirect_pc);
        end
        model_count++;
        wait_ready(cyc);
        n_checks++;
        if (cyc < 0 || taken_count !== model_count) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d (wait %0d) want %0d", taken_count, cyc, model_count);
        end
    endtask

    task automatic test_reset_mid_flush;
        present(3'b010, 32'd1, 32'd2, 32'h400, 32'h10);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b1) begin
            n_fail++;
            $display("FAIL rstflush_pre: got flush=%b want 1", flush);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({flush, stall, req_ready, redirect_valid, taken_count} !== {4'b0010, 32'd0}) begin
            n_fail++;
            $display("FAIL rstflush_post: got flush=%b stall=%b ready=%b redir=%b count=%h",
                     flush, stall, req_ready, redirect_valid, taken_count);
        end
        rst = 1'b0;
        model_count = '0;
    endtask

    task automatic test_busy;
        int acc = 0, rdy = -1;
        present(3'b001, 32'hABCD, 32'hABCD, 32'h500, 32'h4);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (req_ready) begin
                rdy = k;
                break;
            end
            if (resolved_valid) acc++;
        end
        req_valid = 1'b0;
        model_count++;
        n_checks++;
        if (rdy !== FLUSH_N + 3 || acc !== 1) begin
            n_fail++;
            $display("FAIL busy_ready: got ready at T+%0d resolves=%0d want T+%0d resolves=1", rdy, acc, FLUSH_N + 3);
        end
        @(negedge clk);
        n_checks++;
        if (taken_count !== model_count || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_count: got count=%0d stall=%b want %0d 0", taken_count, stall, model_count);
        end
    endtask

    task automatic test_no_flush;
        int rdy = -1, redir_at = -1, nf = 0;
        z_valid = 1'b1;
        z_cntrl = 3'b101;
        z_pc    = 32'h1000;
        z_imm   = 32'hFFFF_FFFC;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (z_flush) nf++;
            if (z_rv && redir_at < 0) redir_at = k;
            if (z_ready) begin
                rdy = k;
                break;
            end
        end
        z_valid = 1'b0;
        n_checks++;
        if (nf !== 0 || redir_at !== 2 || rdy !== 3) begin
            n_fail++;
            $display("FAIL noflush_seq: got flush=%0d redir=T+%0d ready=T+%0d want 0 T+2 T+3", nf, redir_at, rdy);
        end
        n_checks++;
        if (z_rpc !== 32'h0FFC || z_count !== 32'd1) begin
            n_fail++;
            $display("FAIL noflush_vals: got pc=%h count=%0d want 00000ffc 1", z_rpc, z_count);
        end
    endtask

    task automatic test_random;
        logic [2:0]  c;
        logic [31:0] a, b, pc, imm;
        logic        t;
        int          cyc, nf;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            c   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc  = $urandom;
            imm = $urandom;
            t   = exp_take(c, a, b);
            present(c, a, b, pc, imm);
            @(negedge clk);
            req_valid = 1'b0;
            n_checks++;
            if (bu_cntrl !== c || bu_d1 !== a || bu_d2 !== b) begin
                n_fail++;
                $display("FAIL rnd_eval[%0d]: got %b %h %h want %b %h %h", i, bu_cntrl, bu_d1, bu_d2, c, a, b);
            end
            @(negedge clk);
            n_checks++;
            if ({resolved_valid, resolved_taken, redirect_valid, req_ready} !== {1'b1, t, t, ~t} ||
                (t && redirect_pc !== pc + imm)) begin
                n_fail++;
                $display("FAIL rnd_resolve[%0d]: got rv=%b rt=%b redir=%b ready=%b pc=%h want taken=%b pc=%h",
                         i, resolved_valid, resolved_taken, redirect_valid, req_ready, redirect_pc, t, pc + imm);
            end
            if (t) begin
                model_count++;
                nf = 0;
                cyc = -1;
                for (int k = 1; k <= 20; k++) begin
                    @(negedge clk);
                    if (flush) nf++;
                    if (req_ready) begin
                        cyc = k;
                        break;
                    end
                end
                n_checks++;
                if (cyc !== FLUSH_N + 1 || nf !== FLUSH_N || taken_count !== model_count) begin
                    n_fail++;
                    $display("FAIL rnd_taken[%0d]: got ready=%0d flush=%0d count=%0d want %0d %0d %0d",
                             i, cyc, nf, taken_count, FLUSH_N + 1, FLUSH_N, model_count);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_blt_back_to_back();
        test_wrap();
        test_reset_mid_flush();
        test_busy();
        test_no_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
